// File: rtl/ivp_pkg.sv
// ivp_pkg: definitions shared by the IV-bus port and its testbench.
//   sel_e        - which register the last address cycle selected
//   ST_*         - bit positions inside the status register
//   ivp_swap()   - converts between IV-bus levels and data bytes. The bus
//                  is active-low and bit-reversed, so the same transform
//                  works in both directions.
package ivp_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DATA = 2'd1,
    SEL_STAT = 2'd2
  } sel_e;

  localparam int ST_OUT_FULL = 0;
  localparam int ST_IN_FULL  = 1;
  localparam int ST_OUT_OVR  = 2;
  localparam int ST_IN_OVR   = 3;

  function automatic logic [7:0] ivp_swap(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = ~v[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ivp_hold_reg.sv
// ivp_hold_reg: one-entry byte holding register with a full flag and an
// optional sticky overrun flag.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           offer i_load_data to the register
//   i_consume        the holder is being emptied this cycle
//   i_ovr_clr        clear the overrun flag
//   o_data, o_full   stored byte, occupancy
//   o_ovr            sticky overrun: a load arrived while full and not consumed
// DROP_WHEN_FULL=1 keeps the old byte on overrun; 0 overwrites it.
// OVR_EN=0 removes the overrun flag entirely (o_ovr ties to 0).
module ivp_hold_reg #(
  parameter bit DROP_WHEN_FULL = 1'b0,
  parameter bit OVR_EN         = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_consume,
  input  logic       i_ovr_clr,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_ovr
);

  logic [7:0] r_data;
  logic       r_full;
  logic       w_blocked;
  logic       w_take;

  // Blocked means a load this cycle would collide with a byte still held.
  assign w_blocked = r_full & ~i_consume;
  assign w_take    = i_load & ~(DROP_WHEN_FULL & w_blocked);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_take) r_data <= i_load_data;
      // Any load leaves the holder full, even a dropped one.
      if (i_load)         r_full <= 1'b1;
      else if (i_consume) r_full <= 1'b0;
    end
  end

  generate
    if (OVR_EN) begin : g_ovr
      logic r_ovr;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  r_ovr <= 1'b0;
        else if (i_load & w_blocked)   r_ovr <= 1'b1;  // a new overrun beats a clear
        else if (i_ovr_clr)            r_ovr <= 1'b0;
      end
      assign o_ovr = r_ovr;
    end else begin : g_no_ovr
      logic w_unused_ovr_clr;
      assign w_unused_ovr_clr = i_ovr_clr;
      assign o_ovr = 1'b0;
    end
  endgenerate

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/iv_port.sv
// iv_port: addressable 8-bit IV-bus I/O port for the 8X305.
//   x1, reset          clock, asynchronous active-low reset
//   IV                 inout bus (active-low, bit-reversed)
//   LB, RB             bank enables (active-low); BANK picks which one we answer
//   SC, WC, MCLK       select command, write command, instruction clock
//   out_data/valid/ready  bus-to-user byte with valid/ready handshake
//   in_data/in_strobe     user-to-bus byte, loaded on strobe
// Registers: data at BASE, status at BASE+1 (status only with IVP_STATUS_EN).
// Build option: `define IVP_STATUS_EN adds the status register, the overrun
// flags and the clear command. Without it, a write to a full data register
// overwrites the byte.
module iv_port
  import ivp_pkg::*;
#(
  parameter logic [7:0] BASE = 8'h00,
  parameter bit         BANK = 1'b0
) (
  input  logic       x1,
  input  logic       reset,
  inout  wire  [7:0] IV,
  input  logic       LB,
  input  logic       RB,
  input  logic       SC,
  input  logic       WC,
  input  logic       MCLK,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_strobe
);

`ifdef IVP_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  localparam logic [7:0] STAT_ADDR = BASE + 8'd1;

  sel_e       r_sel, w_sel_next;
  logic       r_rd_act;
  logic [7:0] w_bus_val;
  logic       w_bank_act, w_addr_ph, w_wr_ph, w_rd_act;
  logic       w_wr_data, w_wr_stat, w_consume, w_drain;
  logic [7:0] w_in_byte, w_status, w_rd_val;
  logic       w_out_full, w_in_full, w_out_ovr, w_in_ovr;

  assign w_bus_val  = ivp_swap(IV);
  assign w_bank_act = BANK ? ~RB : ~LB;
  assign w_addr_ph  = MCLK & SC & w_bank_act;
  assign w_wr_ph    = MCLK & WC & w_bank_act & ~SC;
  // The CPU input phase: our bank is enabled and neither command is active.
  assign w_rd_act   = w_bank_act & ~SC & ~WC & (r_sel != SEL_NONE);

  always_comb begin
    w_sel_next = r_sel;
    if (w_addr_ph) begin
      if (w_bus_val == BASE)                          w_sel_next = SEL_DATA;
      else if (STATUS_EN && (w_bus_val == STAT_ADDR)) w_sel_next = SEL_STAT;
      else                                            w_sel_next = SEL_NONE;
    end
  end

  always_ff @(posedge x1 or negedge reset) begin
    if (!reset) begin
      r_sel    <= SEL_NONE;
      r_rd_act <= 1'b0;
    end else begin
      r_sel    <= w_sel_next;
      r_rd_act <= w_rd_act;
    end
  end

  assign w_wr_data = w_wr_ph & (r_sel == SEL_DATA);
  assign w_wr_stat = w_wr_ph & (r_sel == SEL_STAT) & w_bus_val[0];
  // The byte is consumed when the read window closes, which also covers a
  // read-modify-write whose WC ends the input phase.
  assign w_consume = r_rd_act & ~w_rd_act & (r_sel == SEL_DATA);
  assign w_drain   = w_out_full & out_ready;

  ivp_hold_reg #(
    .DROP_WHEN_FULL (STATUS_EN),
    .OVR_EN         (STATUS_EN)
  ) u_out_hold (
    .i_clk       (x1),
    .i_rst_n     (reset),
    .i_load      (w_wr_data),
    .i_load_data (w_bus_val),
    .i_consume   (w_drain),
    .i_ovr_clr   (w_wr_stat),
    .o_data      (out_data),
    .o_full      (w_out_full),
    .o_ovr       (w_out_ovr)
  );

  ivp_hold_reg #(
    .DROP_WHEN_FULL (1'b0),
    .OVR_EN         (STATUS_EN)
  ) u_in_hold (
    .i_clk       (x1),
    .i_rst_n     (reset),
    .i_load      (in_strobe),
    .i_load_data (in_data),
    .i_consume   (w_consume),
    .i_ovr_clr   (w_wr_stat),
    .o_data      (w_in_byte),
    .o_full      (w_in_full),
    .o_ovr       (w_in_ovr)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_OUT_FULL] = w_out_full;
    w_status[ST_IN_FULL]  = w_in_full;
    w_status[ST_OUT_OVR]  = w_out_ovr;
    w_status[ST_IN_OVR]   = w_in_ovr;
    w_rd_val = (r_sel == SEL_STAT) ? w_status : w_in_byte;
  end

  // Combinational drive so that an asynchronous reset releases the bus at once.
  assign IV        = w_rd_act ? ivp_swap(w_rd_val) : 8'bz;
  assign out_valid = w_out_full;

endmodule
